// File: rtl/add_digit_sequencer_if.sv
// rtl/add_digit_sequencer_if.sv - digit-pair input stream and sum-digit output stream
// in_sub exists only when ADD_SEQ_SUB_EN is defined.
interface add_digit_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_a;
    logic [2:0] in_b;
    logic       in_last;
`ifdef ADD_SEQ_SUB_EN
    logic       in_sub;
`endif
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_sum;
    logic       out_last;
    logic       out_cout;

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_a,
        input  in_b,
        input  in_last,
`ifdef ADD_SEQ_SUB_EN
        input  in_sub,
`endif
        output out_valid,
        input  out_ready,
        output out_sum,
        output out_last,
        output out_cout
    );

    modport master (
        output in_valid,
        input  in_ready,
        output in_a,
        output in_b,
        output in_last,
`ifdef ADD_SEQ_SUB_EN
        output in_sub,
`endif
        input  out_valid,
        output out_ready,
        input  out_sum,
        input  out_last,
        input  out_cout
    );
endinterface

// File: rtl/add_digit_sequencer.sv
// rtl/add_digit_sequencer.sv - feeds 3-bit digit pairs into three_bit_adder, chaining carry per packet
// Optional subtraction mode is enabled by defining ADD_SEQ_SUB_EN.
module add_digit_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    add_digit_sequencer_if.slave        dig,
    output logic                        trunc_err,
    output logic [2:0]                  add_a,
    output logic [2:0]                  add_b,
    output logic                        add_cin,
    input  logic [2:0]                  add_sum,
    input  logic                        add_cout
);
    localparam int CW = $clog2(WORDS + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

    typedef enum logic {
        FIRST = 1'b0,
        MID   = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   count;
    logic            carry;
    logic            accept;
    logic            at_limit;
    logic            eff_last;
    logic            sub_now;

    assign accept   = dig.in_valid & dig.in_ready;
    assign at_limit = (count == LAST_IDX);
    // A packet reaching WORDS digits is closed even without in_last.
    assign eff_last = dig.in_last | at_limit;

`ifdef ADD_SEQ_SUB_EN
    logic sub_q;
    // Mode is taken from the first digit and held for the rest of the packet.
    assign sub_now = (state == FIRST) ? dig.in_sub : sub_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sub_q <= 1'b0;
        end else if (accept) begin
            sub_q <= sub_now;
        end
    end
`else
    assign sub_now = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FIRST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = eff_last ? FIRST : MID;
        end
    end

    always_comb begin
        dig.in_ready = ~dig.out_valid | dig.out_ready;
        add_a        = dig.in_a;
        add_b        = dig.in_b ^ {3{sub_now}};
        add_cin      = (state == FIRST) ? sub_now : carry;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dig.out_valid <= 1'b0;
            dig.out_sum   <= 3'd0;
            dig.out_last  <= 1'b0;
            dig.out_cout  <= 1'b0;
            trunc_err     <= 1'b0;
            carry         <= 1'b0;
            count         <= '0;
        end else begin
            trunc_err <= accept & ~dig.in_last & at_limit;
            if (accept) begin
                dig.out_valid <= 1'b1;
                dig.out_sum   <= add_sum;
                dig.out_last  <= eff_last;
                dig.out_cout  <= eff_last & add_cout;
                carry         <= add_cout;
                count         <= eff_last ? '0 : count + CW'(1);
            end else if (dig.out_valid & dig.out_ready) begin
                dig.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_add_digit_sequencer.sv
// tb/tb_add_digit_sequencer.sv - self-checking bench for add_digit_sequencer
// Honours ADD_SEQ_SUB_EN when defined.
module tb_add_digit_sequencer;
    localparam int WORDS = 4;
    localparam int NB    = 80;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       trunc_err;
    logic [2:0] add_a, add_b, add_sum;
    logic       add_cin, add_cout;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    add_digit_sequencer_if dif ();

    add_digit_sequencer #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dig       (dif),
        .trunc_err (trunc_err),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    // three_bit_adder stand-in
    always_comb {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {3'b000, add_cin};

    // {trunc_err, in_ready, out_valid, out_last, out_cout, out_sum}
    function automatic logic [7:0] obs();
        return {trunc_err, dif.in_ready, dif.out_valid, dif.out_last, dif.out_cout, dif.out_sum};
    endfunction

    task automatic set_sub(input bit s);
`ifdef ADD_SEQ_SUB_EN
        dif.in_sub = s;
`else
        if (s) $display("note: subtraction not built");
`endif
    endtask

    task automatic send(input logic [2:0] a, input logic [2:0] b, input bit last);
        dif.in_a = a; dif.in_b = b; dif.in_last = last; dif.in_valid = 1'b1;
        @(negedge clk);
        dif.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dif.in_valid = 1'b0; dif.in_last = 1'b0; dif.out_ready = 1'b0;
        dif.in_a = 3'd5; dif.in_b = 3'd2; set_sub(1'b0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (obs() !== 8'b0100_0000) begin
            $display("FAIL reset_outputs: got %b want 01000000", obs()); n_bad++;
        end
        n_cmp++;
        if ({add_a, add_b, add_cin} !== {3'd5, 3'd2, 1'b0}) begin
            $display("FAIL reset_adder_drive: got %b want 1010100", {add_a, add_b, add_cin}); n_bad++;
        end
        rst_n = 1'b1; dif.out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_digit();
        send(3'd5, 3'd4, 1'b1);
        n_cmp++;
        if (obs() !== 8'b0111_1001) begin
            $display("FAIL single_digit: got %b want 01111001", obs()); n_bad++;
        end
        @(negedge clk);
    endtask

    task automatic test_carry_chain();
        send(3'd7, 3'd1, 1'b0);
        n_cmp++;
        if (obs() !== 8'b0110_0000) begin
            $display("FAIL carry_chain_d0: got %b want 01100000", obs()); n_bad++;
        end
        send(3'd0, 3'd0, 1'b1);
        n_cmp++;
        if (obs() !== 8'b0111_0001) begin
            $display("FAIL carry_chain_d1: got %b want 01110001", obs()); n_bad++;
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        dif.out_ready = 1'b0;
        send(3'd1, 3'd2, 1'b0);
        n_cmp++;
        if (obs() !== 8'b0010_0011) begin
            $display("FAIL bp_first: got %b want 00100011", obs()); n_bad++;
        end
        dif.in_a = 3'd2; dif.in_b = 3'd2; dif.in_last = 1'b0; dif.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dif.in_a = 3'($urandom);
            @(negedge clk);
            n_cmp++;
            if (obs() !== 8'b0010_0011) begin
                $display("FAIL bp_stall%0d: got %b want 00100011", i, obs()); n_bad++;
            end
        end
        dif.in_a = 3'd2; dif.out_ready = 1'b1;
        @(negedge clk);
        dif.in_valid = 1'b0;
        n_cmp++;
        if (obs() !== 8'b0110_0100) begin
            $display("FAIL bp_release: got %b want 01100100", obs()); n_bad++;
        end
        send(3'd3, 3'd4, 1'b1);
        n_cmp++;
        if (obs() !== 8'b0111_0111) begin
            $display("FAIL bp_last: got %b want 01110111", obs()); n_bad++;
        end
        @(negedge clk);
    endtask

    task automatic test_truncation();
        logic [7:0] want;
        int         pulses = 0;
        for (int i = 0; i < 4; i++) begin
            send(3'd7, 3'd7, 1'b0);
            pulses += int'(trunc_err);
            want = (i == 0) ? 8'b0110_0110 : (i == 3) ? 8'b1111_1111 : 8'b0110_0111;
            n_cmp++;
            if (obs() !== want) begin
                $display("FAIL trunc_d%0d: got %b want %b", i, obs(), want); n_bad++;
            end
        end
        send(3'd1, 3'd1, 1'b1);
        pulses += int'(trunc_err);
        n_cmp++;
        if (obs() !== 8'b0111_0010) begin
            $display("FAIL trunc_next_packet: got %b want 01110010", obs()); n_bad++;
        end
        n_cmp++;
        if (pulses !== 1) begin
            $display("FAIL trunc_pulse_count: got %0d want 1", pulses); n_bad++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_packet();
        send(3'd7, 3'd7, 1'b0);
        send(3'd7, 3'd7, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (obs() !== 8'b0100_0000 || add_cin !== 1'b0) begin
            $display("FAIL rst_mid_outputs: got %b cin %b want 01000000 cin 0", obs(), add_cin); n_bad++;
        end
        rst_n = 1'b1;
        send(3'd2, 3'd3, 1'b1);
        n_cmp++;
        if (obs() !== 8'b0111_0101) begin
            $display("FAIL rst_mid_new_packet: got %b want 01110101", obs()); n_bad++;
        end
        @(negedge clk);
    endtask

`ifdef ADD_SEQ_SUB_EN
    task automatic test_subtract();
        set_sub(1'b1);
        send(3'd3, 3'd5, 1'b1);
        n_cmp++;
        if (obs() !== 8'b0111_0110) begin
            $display("FAIL sub_borrow: got %b want 01110110", obs()); n_bad++;
        end
        send(3'd5, 3'd3, 1'b1);
        n_cmp++;
        if (obs() !== 8'b0111_1010) begin
            $display("FAIL sub_no_borrow: got %b want 01111010", obs()); n_bad++;
        end
        set_sub(1'b0);
        @(negedge clk);
    endtask
`endif

    task automatic test_random();
        logic [2:0] ba[NB], bb[NB];
        bit         bl[NB], bs[NB];
        logic [4:0] exp_q[$];
        logic [4:0] got;
        int         trunc_exp = 0, trunc_seen = 0, idx = 0, cyc = 0, beat = 0;
        int         len = 0, start = 0, av, bv, sv;
        bit         psub = 1'b0;
`ifdef ADD_SEQ_SUB_EN
        bit         can_sub = 1'b1;
`else
        bit         can_sub = 1'b0;
`endif
        // Reference: split the digit stream into packets, then add whole operands.
        for (int i = 0; i < NB; i++) begin
            if (len == 0) begin
                psub = can_sub & ($urandom_range(0, 1) == 1);
                start = i;
            end
            ba[i] = 3'($urandom); bb[i] = 3'($urandom);
            bl[i] = ($urandom_range(0, 3) == 0) || (i == NB - 1);
            bs[i] = (len == 0) ? psub : (can_sub & ($urandom_range(0, 1) == 1));
            len++;
            if (bl[i] || len == WORDS) begin
                if (!bl[i]) trunc_exp++;
                av = 0; bv = 0;
                for (int k = 0; k < len; k++) begin
                    av += int'(ba[start + k]) << (3 * k);
                    bv += int'(bb[start + k]) << (3 * k);
                end
                sv = psub ? av + ((1 << (3 * len)) - bv) : av + bv;
                for (int k = 0; k < len; k++)
                    exp_q.push_back({(k == len - 1) ? 1'((sv >> (3 * len)) & 1) : 1'b0,
                                     k == len - 1, 3'((sv >> (3 * k)) & 7)});
                len = 0;
            end
        end
        dif.out_ready = 1'b1; dif.in_valid = 1'b0;
        @(negedge clk);
        while ((idx < NB || exp_q.size() > 0) && cyc < 3000) begin
            trunc_seen += int'(trunc_err);
            dif.out_ready = ($urandom_range(0, 3) != 0);
            if (idx < NB && $urandom_range(0, 3) != 0) begin
                dif.in_valid = 1'b1; dif.in_a = ba[idx]; dif.in_b = bb[idx]; dif.in_last = bl[idx];
                set_sub(bs[idx]);
            end else begin
                dif.in_valid = 1'b0; dif.in_a = 3'($urandom); dif.in_b = 3'($urandom);
            end
            #1;
            if (dif.out_valid && dif.out_ready) begin
                got = {dif.out_cout, dif.out_last, dif.out_sum};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rand_extra_beat: got %b want none", got); n_bad++;
                end else if (got !== exp_q[0]) begin
                    $display("FAIL rand_beat%0d: got cout/last/sum %b want %b", beat, got, exp_q[0]); n_bad++;
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
                beat++;
            end
            if (dif.in_valid && dif.in_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        dif.in_valid = 1'b0; set_sub(1'b0);
        trunc_seen += int'(trunc_err);
        n_cmp++;
        if (idx != NB || exp_q.size() != 0) begin
            $display("FAIL rand_timeout: sent %0d of %0d, %0d beats outstanding", idx, NB, exp_q.size()); n_bad++;
        end
        n_cmp++;
        if (trunc_seen != trunc_exp) begin
            $display("FAIL rand_trunc_count: got %0d want %0d", trunc_seen, trunc_exp); n_bad++;
        end
    endtask

    initial begin
        test_reset();
        test_single_digit();
        test_carry_chain();
        test_backpressure();
        test_truncation();
        test_reset_mid_packet();
`ifdef ADD_SEQ_SUB_EN
        test_subtract();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
